// File: rtl/mod_symbol_sequencer.sv
// mod_symbol_sequencer: symbol-rate controller for the modulate datapath.
// Takes payload bytes over a valid/ready handshake and serialises them
// MSB-first into symbols held SYM_CYCLES clocks each. QPSK (mode 3'b100)
// carries 2 bits per symbol; every other mode carries 1 bit per symbol.
// Optional feature macro: MOD_PREAMBLE_EN inserts PRE_SYMS preamble symbols
// whenever a frame leaves IDLE.
module mod_symbol_sequencer #(
  parameter int SYM_CYCLES = 1024,
  parameter int PRE_SYMS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_in,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [2:0] mod_sel,
  output logic [1:0] en,
  output logic       sym_strobe,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0]  MODE_QPSK = 3'b100;
  localparam logic [15:0] CNT_LAST  = 16'(SYM_CYCLES - 1);
`ifdef MOD_PREAMBLE_EN
  localparam logic [15:0] PRE_LAST  = 16'(PRE_SYMS - 1);
`endif

  // Reject parameter values the 16-bit symbol counter cannot represent.
  if (SYM_CYCLES < 1 || SYM_CYCLES > 65535 || PRE_SYMS < 1) begin : g_bad_param
    $error("mod_symbol_sequencer: SYM_CYCLES or PRE_SYMS out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef MOD_PREAMBLE_EN
    ST_PREAMBLE,
`endif
    ST_SHIFT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;           // cycle within the current symbol
  logic [2:0]  sym_left_q, sym_left_d; // symbols of the byte still to emit
  logic [7:0]  shift_q, shift_d;       // bits not yet emitted, MSB-aligned
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [2:0]  mod_sel_q, mod_sel_d;
  logic [1:0]  en_q, en_d;
  logic        strobe_q, strobe_d;
  logic        done_q, done_d;
`ifdef MOD_PREAMBLE_EN
  logic [15:0] pre_q, pre_d;           // preamble symbol index
`endif

  logic       xfer;
  logic       bps2_cur;
  logic       bps2_new;
  logic       cnt_tc;
  logic       load;
  logic [7:0] load_byte;
  logic       load_bps2;

  assign data_ready = !hold_full_q;
  assign xfer       = data_valid && data_ready;
  assign bps2_cur   = (mod_sel_q == MODE_QPSK);
  assign bps2_new   = (mode_in == MODE_QPSK);
  assign cnt_tc     = (cnt_q == CNT_LAST);

  assign mod_sel    = mod_sel_q;
  assign en         = en_q;
  assign sym_strobe = strobe_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

  // First symbol taken from the top of a byte.
  function automatic logic [1:0] first_sym(input logic [7:0] b, input logic bps2);
    return bps2 ? b[7:6] : {1'b0, b[7]};
  endfunction

  // Byte left after removing its first symbol.
  function automatic logic [7:0] after_sym(input logic [7:0] b, input logic bps2);
    return bps2 ? {b[5:0], 2'b00} : {b[6:0], 1'b0};
  endfunction

  // Next-state, symbol sequencing and holding-register control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_left_d  = sym_left_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    mod_sel_d   = mod_sel_q;
    en_d        = en_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;
    load_byte   = data_in;
    load_bps2   = bps2_cur;
`ifdef MOD_PREAMBLE_EN
    pre_d       = pre_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          mod_sel_d = mode_in;
          cnt_d     = '0;
          strobe_d  = 1'b1;
`ifdef MOD_PREAMBLE_EN
          // The byte waits unshifted while the preamble plays out.
          state_d   = ST_PREAMBLE;
          shift_d   = data_in;
          pre_d     = '0;
          en_d      = bps2_new ? 2'b00 : 2'b01;
`else
          state_d   = ST_SHIFT;
          load      = 1'b1;
          load_bps2 = bps2_new;
`endif
        end
      end

`ifdef MOD_PREAMBLE_EN
      ST_PREAMBLE: begin
        if (xfer) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
        if (cnt_tc) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          if (pre_q == PRE_LAST) begin
            state_d   = ST_SHIFT;
            load      = 1'b1;
            load_byte = shift_q;
          end else begin
            pre_d = pre_q + 16'd1;
            // Even indices: 01 (1 bps) / 00 (2 bps); odd: 00 / 11.
            if (pre_q[0]) en_d = bps2_cur ? 2'b00 : 2'b01;
            else          en_d = bps2_cur ? 2'b11 : 2'b00;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif

      ST_SHIFT: begin
        // A mid-byte handshake parks the byte in the holding register.
        if (xfer) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
        if (cnt_tc) begin
          cnt_d = '0;
          if (sym_left_q != 3'd0) begin
            en_d       = first_sym(shift_q, bps2_cur);
            shift_d    = after_sym(shift_q, bps2_cur);
            sym_left_d = sym_left_q - 3'd1;
            strobe_d   = 1'b1;
          end else if (hold_full_q) begin
            load        = 1'b1;
            load_byte   = hold_q;
            hold_full_d = 1'b0;
            strobe_d    = 1'b1;
          end else if (xfer) begin
            // Handshake exactly on the byte boundary: stream straight on.
            load        = 1'b1;
            load_byte   = data_in;
            hold_full_d = 1'b0;
            strobe_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
            en_d    = 2'b00;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      en_d       = first_sym(load_byte, load_bps2);
      shift_d    = after_sym(load_byte, load_bps2);
      sym_left_d = load_bps2 ? 3'd3 : 3'd7;
    end
  end

  // State registers; reset aborts any frame and drops any byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sym_left_q  <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      mod_sel_q   <= 3'b000;
      en_q        <= 2'b00;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef MOD_PREAMBLE_EN
      pre_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_left_q  <= sym_left_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      mod_sel_q   <= mod_sel_d;
      en_q        <= en_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
`ifdef MOD_PREAMBLE_EN
      pre_q       <= pre_d;
`endif
    end
  end

endmodule

// File: tb/tb_mod_symbol_sequencer.sv
// Directed testbench for mod_symbol_sequencer. Two instances share the
// clock and reset: one with SYM_CYCLES=4 and one with SYM_CYCLES=1.
// With MOD_PREAMBLE_EN defined the preamble scenario replaces the plain
// frame scenarios.
module tb_mod_symbol_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode_in = 3'b000;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       sel = 1'b0;   // 0 selects the SYM_CYCLES=4 instance

  logic       valid4, valid1;
  logic       ready4, ready1, strobe4, strobe1, busy4, busy1, done4, done1;
  logic [2:0] msel4, msel1;
  logic [1:0] en4, en1;

  logic       o_ready, o_strobe, o_busy, o_done;
  logic [2:0] o_msel;
  logic [1:0] o_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_syms[$];

  always #5 clk = ~clk;

  assign valid4   = valid && !sel;
  assign valid1   = valid && sel;
  assign o_ready  = sel ? ready1  : ready4;
  assign o_strobe = sel ? strobe1 : strobe4;
  assign o_busy   = sel ? busy1   : busy4;
  assign o_done   = sel ? done1   : done4;
  assign o_msel   = sel ? msel1   : msel4;
  assign o_en     = sel ? en1     : en4;

  mod_symbol_sequencer #(.SYM_CYCLES(4), .PRE_SYMS(4)) dut4 (
    .clk(clk), .reset(reset), .mode_in(mode_in), .data_in(data_in),
    .data_valid(valid4), .data_ready(ready4), .mod_sel(msel4), .en(en4),
    .sym_strobe(strobe4), .busy(busy4), .done(done4)
  );

  mod_symbol_sequencer #(.SYM_CYCLES(1), .PRE_SYMS(4)) dut1 (
    .clk(clk), .reset(reset), .mode_in(mode_in), .data_in(data_in),
    .data_valid(valid1), .data_ready(ready1), .mod_sel(msel1), .en(en1),
    .sym_strobe(strobe1), .busy(busy1), .done(done1)
  );

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Append the symbols of one byte to exp_syms.
  task automatic push_byte(input logic [7:0] b, input bit bps2);
    if (bps2) begin
      for (int i = 0; i < 4; i++) exp_syms.push_back({b[7-2*i], b[6-2*i]});
    end else begin
      for (int i = 0; i < 8; i++) exp_syms.push_back({1'b0, b[7-i]});
    end
  endtask

  // Called at the negedge of cycle N+1+skip after the opening handshake;
  // checks every cycle of the frame, then the done pulse.
  task automatic check_stream(input string tag, input int sc, input int skip, input logic [2:0] msel);
    int total;
    total = sc * exp_syms.size();
    for (int t = skip; t < total; t++) begin
      check_value({tag, "_en"},   {6'd0, o_en},     {6'd0, exp_syms[t / sc]});
      check_value({tag, "_stb"},  {7'd0, o_strobe}, {7'd0, ((t % sc) == 0)});
      check_value({tag, "_busy"}, {7'd0, o_busy},   8'd1);
      check_value({tag, "_done"}, {7'd0, o_done},   8'd0);
      check_value({tag, "_msel"}, {5'd0, o_msel},   {5'd0, msel});
      @(negedge clk);
    end
    check_value({tag, "_done_pulse"}, {7'd0, o_done},   8'd1);
    check_value({tag, "_done_busy"},  {7'd0, o_busy},   8'd0);
    check_value({tag, "_done_en"},    {6'd0, o_en},     8'd0);
    check_value({tag, "_done_stb"},   {7'd0, o_strobe}, 8'd0);
    @(negedge clk);
    check_value({tag, "_done_clr"},   {7'd0, o_done},   8'd0);
    $display("txn %s: %0d symbols checked", tag, exp_syms.size());
    exp_syms.delete();
  endtask

  // Start a frame: handshake on the next rising edge.
  task automatic offer(input logic [7:0] b, input logic [2:0] m);
    @(negedge clk);
    data_in = b;
    mode_in = m;
    valid   = 1'b1;
  endtask

  initial begin
    int stb_cnt;
    int busy_cnt;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check_value("rst_ready", {7'd0, o_ready},  8'd1);
      check_value("rst_busy",  {7'd0, o_busy},   8'd0);
      check_value("rst_en",    {6'd0, o_en},     8'd0);
      check_value("rst_msel",  {5'd0, o_msel},   8'd0);
      check_value("rst_stb",   {7'd0, o_strobe}, 8'd0);
      check_value("rst_done",  {7'd0, o_done},   8'd0);
    end
    sel = 1'b0;
    $display("txn reset: idle outputs checked");

`ifdef MOD_PREAMBLE_EN
    // Preamble 01,00,01,00 then byte F0 at 1 bit per symbol.
    offer(8'hF0, 3'b000);
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_syms.push_back(i[0] ? 2'b00 : 2'b01);
    push_byte(8'hF0, 1'b0);
    check_stream("pre_F0", 4, 0, 3'b000);
`else
    // Single byte A5, 1 bit per symbol.
    offer(8'hA5, 3'b000);
    @(negedge clk);
    valid = 1'b0;
    push_byte(8'hA5, 1'b0);
    check_stream("ask_A5", 4, 0, 3'b000);

    // QPSK byte 1B -> 00,01,10,11.
    offer(8'h1B, 3'b100);
    @(negedge clk);
    valid = 1'b0;
    exp_syms = '{2'b00, 2'b01, 2'b10, 2'b11};
    check_stream("qpsk_1B", 4, 0, 3'b100);

    // Back-to-back FF then 00; mode change mid-frame must be ignored.
    offer(8'hFF, 3'b000);
    @(negedge clk);
    data_in = 8'h00;
    mode_in = 3'b010;
    @(negedge clk);
    valid = 1'b0;
    check_value("b2b_ready_drop", {7'd0, o_ready}, 8'd0);
    push_byte(8'hFF, 1'b0);
    push_byte(8'h00, 1'b0);
    check_stream("b2b_FF_00", 4, 1, 3'b000);
    check_value("b2b_ready_back", {7'd0, o_ready}, 8'd1);

    // One symbol per clock, streaming 80 then 01.
    sel = 1'b1;
    offer(8'h80, 3'b000);
    @(negedge clk);
    data_in = 8'h01;
    @(negedge clk);
    valid = 1'b0;
    push_byte(8'h80, 1'b0);
    push_byte(8'h01, 1'b0);
    check_stream("sc1_80_01", 1, 1, 3'b000);
    sel = 1'b0;
`endif

    // Reset mid-symbol with a held byte pending.
    offer(8'hC3, 3'b011);
    @(negedge clk);
    data_in = 8'h3C;
    @(negedge clk);
    valid = 1'b0;
    check_value("abort_hold_full", {7'd0, o_ready}, 8'd0);
    check_value("abort_busy_pre",  {7'd0, o_busy},  8'd1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_value("abort_en",    {6'd0, o_en},     8'd0);
    check_value("abort_msel",  {5'd0, o_msel},   8'd0);
    check_value("abort_stb",   {7'd0, o_strobe}, 8'd0);
    check_value("abort_busy",  {7'd0, o_busy},   8'd0);
    check_value("abort_done",  {7'd0, o_done},   8'd0);
    check_value("abort_ready", {7'd0, o_ready},  8'd1);
    @(negedge clk);
    reset = 1'b0;
    stb_cnt  = 0;
    busy_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_strobe) stb_cnt++;
      if (o_busy || o_done || (o_en != 2'b00)) busy_cnt++;
    end
    check_value("abort_no_strobe", 8'(stb_cnt),  8'd0);
    check_value("abort_quiet",     8'(busy_cnt), 8'd0);
    check_value("abort_ready_end", {7'd0, o_ready}, 8'd1);
    $display("txn abort: reset mid-symbol checked");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
